// File: rtl/p1_pool_sched.sv
// 2x2 max-pool sequencer for P1, two row-half lanes walked in parallel.
// Define P1_POOL_SCHED_PERF_EN to add the stall_cnt write-backpressure counter.
module p1_pool_sched #(
  parameter int IN_DIM = 24,
  parameter int OUT_DIM = 12,
  parameter int RD_LAT = 1,
  parameter int IN_AW = 10,
  parameter int OUT_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IN_AW-1:0]  rd_addr0,
  output logic [IN_AW-1:0]  rd_addr1,
  output logic              pool_valid,
  output logic              pool_first,
  output logic              wr_en,
  output logic [OUT_AW-1:0] wr_addr0,
  output logic [OUT_AW-1:0] wr_addr1,
  input  logic              wr_ready
`ifdef P1_POOL_SCHED_PERF_EN
  ,output logic [15:0]      stall_cnt
`endif
);

  localparam int CW = $clog2(OUT_DIM);
  localparam int RD_OFF = (OUT_DIM / 2) * 2 * IN_DIM;
  localparam int WR_OFF = (OUT_DIM / 2) * OUT_DIM;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] r_q, r_d, c_q, c_d;
  logic [1:0] k_q, k_d;
  logic [2:0] w_q, w_d;
  logic last;

  logic busy_q, done_q, rd_en_q, wr_en_q;
  logic [IN_AW-1:0] rd_a0_q, rd_a1_q, rd_a0;
  logic [OUT_AW-1:0] wr_a0_q, wr_a1_q, wr_a0;
  logic [RD_LAT-1:0] pv_q, pf_q;

  assign last = (r_q == CW'(OUT_DIM / 2 - 1))
             && (c_q == CW'(OUT_DIM - 1));

  always_comb begin
    state_d = state_q;
    r_d = r_q;
    c_d = c_q;
    k_d = k_q;
    w_d = w_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          r_d = '0;
          c_d = '0;
          k_d = '0;
        end
      end
      S_READ: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = S_WAIT;
          w_d = '0;
        end
      end
      S_WAIT: begin
        if (w_q == 3'(RD_LAT - 1)) state_d = S_WRITE;
        else w_d = w_q + 3'd1;
      end
      S_WRITE: begin
        if (wr_ready) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            k_d = '0;
            if (c_q == CW'(OUT_DIM - 1)) begin
              c_d = '0;
              r_d = r_q + CW'(1);
            end else begin
              c_d = c_q + CW'(1);
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they align with the state.
  assign rd_a0 = IN_AW'((2 * int'(r_d) + int'(k_d[1])) * IN_DIM
                 + 2 * int'(c_d) + int'(k_d[0]));
  assign wr_a0 = OUT_AW'(int'(r_d) * OUT_DIM + int'(c_d));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
      w_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      rd_a0_q <= '0;
      rd_a1_q <= '0;
      wr_a0_q <= '0;
      wr_a1_q <= '0;
      pv_q <= '0;
      pf_q <= '0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      c_q <= c_d;
      k_q <= k_d;
      w_q <= w_d;
      busy_q <= (state_d == S_READ) || (state_d == S_WAIT)
             || (state_d == S_WRITE);
      done_q <= (state_d == S_DONE);
      rd_en_q <= (state_d == S_READ);
      wr_en_q <= (state_d == S_WRITE);
      if (state_d == S_READ) begin
        rd_a0_q <= rd_a0;
        rd_a1_q <= rd_a0 + IN_AW'(RD_OFF);
      end
      if (state_d == S_WRITE) begin
        wr_a0_q <= wr_a0;
        wr_a1_q <= wr_a0 + OUT_AW'(WR_OFF);
      end else begin
        wr_a0_q <= '0;
        wr_a1_q <= '0;
      end
      pv_q <= RD_LAT'({pv_q, rd_en_q});
      pf_q <= RD_LAT'({pf_q, rd_en_q & (k_q == 2'd0)});
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign rd_en = rd_en_q;
  assign rd_addr0 = rd_a0_q;
  assign rd_addr1 = rd_a1_q;
  assign wr_en = wr_en_q;
  assign wr_addr0 = wr_a0_q;
  assign wr_addr1 = wr_a1_q;
  assign pool_valid = pv_q[RD_LAT-1];
  assign pool_first = pf_q[RD_LAT-1];

`ifdef P1_POOL_SCHED_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
    end else if (state_q == S_WRITE && !wr_ready
                 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_p1_pool_sched.sv
// Directed bench for p1_pool_sched: RD_LAT=1 and RD_LAT=3 instances.
// Covers window timing, full-pass counts, backpressure and mid-pass reset.
module tb_p1_pool_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, wr_ready, sel;
  logic start_a, start_b;
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  logic a_busy, a_done, a_rd_en, a_pv, a_pf, a_wr_en;
  logic [9:0] a_ra0, a_ra1;
  logic [7:0] a_wa0, a_wa1;
  logic b_busy, b_done, b_rd_en, b_pv, b_pf, b_wr_en;
  logic [9:0] b_ra0, b_ra1;
  logic [7:0] b_wa0, b_wa1;
`ifdef P1_POOL_SCHED_PERF_EN
  logic [15:0] a_stall, b_stall;
`endif

  p1_pool_sched #(.RD_LAT(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a),
    .busy(a_busy), .done(a_done), .rd_en(a_rd_en),
    .rd_addr0(a_ra0), .rd_addr1(a_ra1),
    .pool_valid(a_pv), .pool_first(a_pf),
    .wr_en(a_wr_en), .wr_addr0(a_wa0), .wr_addr1(a_wa1),
    .wr_ready(wr_ready)
`ifdef P1_POOL_SCHED_PERF_EN
    , .stall_cnt(a_stall)
`endif
  );

  p1_pool_sched #(.RD_LAT(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b),
    .busy(b_busy), .done(b_done), .rd_en(b_rd_en),
    .rd_addr0(b_ra0), .rd_addr1(b_ra1),
    .pool_valid(b_pv), .pool_first(b_pf),
    .wr_en(b_wr_en), .wr_addr0(b_wa0), .wr_addr1(b_wa1),
    .wr_ready(wr_ready)
`ifdef P1_POOL_SCHED_PERF_EN
    , .stall_cnt(b_stall)
`endif
  );

  logic o_busy, o_done, o_rd_en, o_pv, o_pf, o_wr_en;
  logic [9:0] o_ra0, o_ra1;
  logic [7:0] o_wa0, o_wa1;
  logic [41:0] o_all;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_rd_en = sel ? b_rd_en : a_rd_en;
  assign o_pv = sel ? b_pv : a_pv;
  assign o_pf = sel ? b_pf : a_pf;
  assign o_wr_en = sel ? b_wr_en : a_wr_en;
  assign o_ra0 = sel ? b_ra0 : a_ra0;
  assign o_ra1 = sel ? b_ra1 : a_ra1;
  assign o_wa0 = sel ? b_wa0 : a_wa0;
  assign o_wa1 = sel ? b_wa1 : a_wa1;
  assign o_all = {o_busy, o_done, o_rd_en, o_pv, o_pf, o_wr_en,
                  o_ra0, o_ra1, o_wa0, o_wa1};

  int total = 0;
  int passes = 0;
  int rq0[$], rq1[$], wq0[$], wq1[$];
  int e_w0[4] = '{0, 1, 24, 25};
  int e_w13[4] = '{50, 51, 74, 75};
  int e_last[4] = '{262, 263, 286, 287};
  int busy_n, done_n;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic run_pass(input int lat, input int stall_from,
                          output int bn, output int dn);
    int w;
    int n;
    bit fin;
    w = 5 + lat;
    bn = 0;
    dn = 0;
    n = 0;
    fin = 1'b0;
    rq0.delete(); rq1.delete(); wq0.delete(); wq1.delete();
    @(negedge clk);
    start = 1'b1;
    wr_ready = 1'b1;
    while (!fin && n < 2000) begin
      @(negedge clk);
      n++;
      start = (n == 100) || o_done;
      wr_ready = !(stall_from > 0 && n >= stall_from
                   && n < stall_from + 5);
      if (o_busy) bn++;
      if (o_done) begin
        dn++;
        fin = 1'b1;
      end
      if (o_rd_en) begin
        rq0.push_back(int'(o_ra0));
        rq1.push_back(int'(o_ra1));
      end
      if (o_wr_en && wr_ready) begin
        wq0.push_back(int'(o_wa0));
        wq1.push_back(int'(o_wa1));
      end
      if (n <= w) begin
        chk("w0_rd_en", o_rd_en, n <= 4);
        chk("w0_pool_valid", o_pv, n > lat && n <= 4 + lat);
        chk("w0_pool_first", o_pf, n == lat + 1);
        chk("w0_wr_en", o_wr_en, n == w);
      end
      if (stall_from > 0 && n >= stall_from && n <= stall_from + 5)
        chk("bp_hold", {o_wr_en, o_rd_en, o_wa0, o_wa1},
            {1'b1, 1'b0, 8'd3, 8'd75});
    end
    @(negedge clk);
    chk("done_no_retrigger", {o_busy, o_done}, 0);
    start = 1'b0;
  endtask

  task automatic chk_addrs();
    chk("n_reads", rq0.size(), 288);
    chk("n_writes", wq0.size(), 72);
    for (int i = 0; i < 4; i++) begin
      chk("w0_rd0", rq0[i], e_w0[i]);
      chk("w0_rd1", rq1[i], e_w0[i] + 288);
      chk("w13_rd0", rq0[52+i], e_w13[i]);
      chk("w13_rd1", rq1[52+i], e_w13[i] + 288);
      chk("last_rd0", rq0[284+i], e_last[i]);
      chk("last_rd1", rq1[284+i], e_last[i] + 288);
    end
    chk("w0_wr0", wq0[0], 0);
    chk("w0_wr1", wq1[0], 72);
    chk("w13_wr0", wq0[13], 13);
    chk("w13_wr1", wq1[13], 85);
    chk("last_wr0", wq0[71], 71);
    chk("last_wr1", wq1[71], 143);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    wr_ready = 1'b1;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_a", o_all, 0);
    sel = 1'b1;
    #1 chk("reset_b", o_all, 0);
`ifdef P1_POOL_SCHED_PERF_EN
    chk("reset_stall", a_stall, 0);
`endif
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    run_pass(1, 0, busy_n, done_n);
    chk("pass1_busy", busy_n, 432);
    chk("pass1_done", done_n, 1);
    chk_addrs();
`ifdef P1_POOL_SCHED_PERF_EN
    chk("pass1_stall", a_stall, 0);
`endif

    run_pass(1, 24, busy_n, done_n);
    chk("bp_busy", busy_n, 437);
    chk("bp_done", done_n, 1);
    chk("bp_writes", wq0.size(), 72);
`ifdef P1_POOL_SCHED_PERF_EN
    chk("bp_stall", a_stall, 5);
`endif

    sel = 1'b1;
    run_pass(3, 0, busy_n, done_n);
    chk("lat3_busy", busy_n, 576);
    chk("lat3_done", done_n, 1);
    chk_addrs();
    sel = 1'b0;

    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 122; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("w20_rd0", o_ra0, 65);
    #1 reset = 1'b1;
    #1 chk("async_reset", o_all, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    done_n = 0;
    busy_n = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (o_done) done_n++;
      if (o_busy) busy_n++;
    end
    chk("abort_no_done", done_n, 0);
    chk("abort_idle", busy_n, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_rd0", {o_rd_en, o_ra0, o_ra1}, {1'b1, 10'd0, 10'd288});
    repeat (5) @(negedge clk);
    chk("restart_wr", {o_wr_en, o_wa0, o_wa1}, {1'b1, 8'd0, 8'd72});
    reset = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
